sparse_mac_array: RTL

//  Multi-channel sparse dot-product engine for one activation block against NUM_CH weight blocks.

---
 rtl/sparse_mac_pkg.sv | 42 ++++
 rtl/sparse_flg_scan.sv | 50 +++++
 rtl/sparse_mac_array.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sparse_mac_pkg.sv
// Shared definitions for sparse_mac_array: default sizes, FSM states, flag-bitmap helpers.
// Latency: none (types and pure combinational functions only).
// Backpressure: none.
package sparse_mac_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int BLK_DEPTH_DEF = 32;
  localparam int NUM_CH_DEF    = 4;

  // Helpers work on one fixed width; narrower flag vectors are zero-extended by the caller.
  localparam int MAX_DEPTH     = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Accumulator width: full product plus headroom for a block of products and the injected psum.
  function automatic int acc_width(input int data_w, input int blk_depth);
    return 2 * data_w + $clog2(3 * blk_depth);
  endfunction

  function automatic int popcount(input logic [MAX_DEPTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) n += int'(v[i]);
    return n;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int lowest_set(input logic [MAX_DEPTH-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sparse_flg_scan.sv
// Per-channel match scanner: holds the act&wei match mask and walks it lowest-bit-first.
// Latency: addresses are combinational from the mask; the mask retires one bit per step edge.
// Backpressure: none; advances only when step is asserted by the owning FSM.
module sparse_flg_scan
  import sparse_mac_pkg::*;
#(
  parameter int BLK_DEPTH = BLK_DEPTH_DEF,
  parameter int AW        = $clog2(BLK_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [BLK_DEPTH-1:0] mask_init,
  input  logic [BLK_DEPTH-1:0] flg_act,
  input  logic [BLK_DEPTH-1:0] flg_wei,
  output logic                 vld,
  output logic                 empty,
  output logic                 last,
  output logic [AW-1:0]        act_addr,
  output logic [AW-1:0]        wei_addr
);

  logic [BLK_DEPTH-1:0] mask;
  logic [BLK_DEPTH-1:0] pos_bit;
  logic [BLK_DEPTH-1:0] below;
  int                   pos;

  // Locate the lowest pending match and rank it within each compressed operand stream.
  always_comb begin
    pos      = lowest_set(MAX_DEPTH'(mask));
    pos_bit  = BLK_DEPTH'(1) << pos;
    below    = pos_bit - BLK_DEPTH'(1);
    act_addr = AW'(popcount(MAX_DEPTH'(flg_act & below)));
    wei_addr = AW'(popcount(MAX_DEPTH'(flg_wei & below)));
  end

  assign empty = ~|mask;
  assign vld   = ~empty;
  // Exactly one match left: this step empties the mask.
  assign last  = ~empty && ((mask & (mask - BLK_DEPTH'(1))) == '0);

  // Load the intersection on accept, then retire one match per scan cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    mask <= '0;
    else if (load) mask <= mask_init;
    else if (step) mask <= mask & ~pos_bit;
  end

endmodule

// File: rtl/sparse_mac_array.sv
// Sparse dot-product engine: one activation block against NUM_CH zero-compressed weight blocks.
// Latency: out_valid rises max(K_max,1)+1 edges after accept (K_max = largest channel match count).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional: SPARSE_MAC_SAT_EN.
module sparse_mac_array
  import sparse_mac_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BLK_DEPTH = BLK_DEPTH_DEF,
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int ACC_W     = acc_width(DATA_W, BLK_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BLK_DEPTH-1:0]              in_flg_act,
  input  logic [DATA_W*BLK_DEPTH-1:0]       in_act,
  input  logic [NUM_CH*BLK_DEPTH-1:0]       in_flg_wei,
  input  logic [NUM_CH*DATA_W*BLK_DEPTH-1:0] in_wei,
  input  logic [NUM_CH*ACC_W-1:0]           in_psum,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CH*ACC_W-1:0]           out_psum,
  output logic [NUM_CH-1:0]                 out_sat
);

  localparam int AW = $clog2(BLK_DEPTH);

  state_t state, state_nxt;
  logic   accept;
  logic   scan_en;
  logic   scan_done;

  logic [BLK_DEPTH-1:0]               flg_act_q;
  logic [NUM_CH*BLK_DEPTH-1:0]        flg_wei_q;
  logic [DATA_W*BLK_DEPTH-1:0]        act_q;
  logic [NUM_CH*DATA_W*BLK_DEPTH-1:0] wei_q;

  logic [NUM_CH-1:0]         scan_vld;
  logic [NUM_CH-1:0]         scan_empty;
  logic [NUM_CH-1:0]         scan_last;
  logic [NUM_CH-1:0][AW-1:0] act_addr;
  logic [NUM_CH-1:0][AW-1:0] wei_addr;

  // Scanning finishes once every channel has issued its final match (or had none).
  assign scan_done = &(scan_empty | scan_last);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SCAN;
      SCAN:    if (scan_done) state_nxt = DRAIN;
      DRAIN:                  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshakes and pipeline enables.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = (state == IDLE) && in_valid;
    scan_en   = (state == SCAN);
  end

  // Capture the whole compressed block on accept; it stays put until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flg_act_q <= '0;
      flg_wei_q <= '0;
      act_q     <= '0;
      wei_q     <= '0;
    end else if (accept) begin
      flg_act_q <= in_flg_act;
      flg_wei_q <= in_flg_wei;
      act_q     <= in_act;
      wei_q     <= in_wei;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                       iss_vld;
    logic signed [DATA_W-1:0]   iss_act;
    logic signed [DATA_W-1:0]   iss_wei;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]      sum;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_nxt;

    sparse_flg_scan #(
      .BLK_DEPTH (BLK_DEPTH),
      .AW        (AW)
    ) u_scan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .step      (scan_en),
      .mask_init (in_flg_act & in_flg_wei[c*BLK_DEPTH +: BLK_DEPTH]),
      .flg_act   (flg_act_q),
      .flg_wei   (flg_wei_q[c*BLK_DEPTH +: BLK_DEPTH]),
      .vld       (scan_vld[c]),
      .empty     (scan_empty[c]),
      .last      (scan_last[c]),
      .act_addr  (act_addr[c]),
      .wei_addr  (wei_addr[c])
    );

    // Issue stage: fetch the operand pair for this cycle's match; empty channels issue a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        iss_vld <= 1'b0;
        iss_act <= '0;
        iss_wei <= '0;
      end else begin
        iss_vld <= scan_en && scan_vld[c];
        if (scan_en && scan_vld[c]) begin
          iss_act <= act_q[int'(act_addr[c])*DATA_W +: DATA_W];
          iss_wei <= wei_q[(c*BLK_DEPTH + int'(wei_addr[c]))*DATA_W +: DATA_W];
        end
      end
    end

    assign prod = (2*DATA_W)'(iss_act) * (2*DATA_W)'(iss_wei);
    assign sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);

`ifdef SPARSE_MAC_SAT_EN
    logic ovf;
    logic sat_q;

    // Clamp to the signed range when the extra sum bit disagrees with the accumulator sign bit.
    always_comb begin
      ovf = sum[ACC_W] ^ sum[ACC_W-1];
      if (!ovf)          acc_nxt = sum[ACC_W-1:0];
      else if (sum[ACC_W]) acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
      else               acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
    end

    // Sticky clamp indicator, cleared only when a new block is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                sat_q <= 1'b0;
      else if (accept)           sat_q <= 1'b0;
      else if (iss_vld && ovf)   sat_q <= 1'b1;
    end

    assign out_sat[c] = sat_q;
`else
    // Plain two's-complement wrap at the accumulator width.
    always_comb begin
      acc_nxt = sum[ACC_W-1:0];
    end
`endif

    // Execute stage: seed from the injected psum, then add each issued product.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       acc <= '0;
      else if (accept)  acc <= $signed(in_psum[c*ACC_W +: ACC_W]);
      else if (iss_vld) acc <= acc_nxt;
    end

    assign out_psum[c*ACC_W +: ACC_W] = acc;
  end

`ifndef SPARSE_MAC_SAT_EN
  assign out_sat = '0;
`endif

endmodule
